// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter; define UART_TX_FIFO_EN for a FIFO_DEPTH-entry
// byte FIFO, otherwise a single holding register buffers the next byte.
module uart_tx_dev #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  write_enable,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        tx
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [BW-1:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift, head;
  logic overflow, empty, full, push, pop, accept, busy, bit_end, unused;
  assign unused = ^{addr[31:3], addr[1:0], data_in[31:8]} ^ FIFO_DEPTH[0];
  assign push = en && |write_enable && !addr[2];
  assign bit_end = baud_cnt == BAUD_LAST;
  // the FSM pulls the next byte either from idle or at the end of a stop bit
  assign pop = !empty && (state == IDLE || (state == STOP && bit_end));
  assign accept = push && (!full || pop);
  assign busy = state != IDLE || !empty;
  assign data_out = en ? (addr[2] ? {28'h0, overflow, empty, full, busy} : 32'h0) : 'z;
`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  assign empty = count == '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr] <= data_in[7:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(accept) - CW'(pop);
    end
`else
  logic hold_valid;
  logic [7:0] hold;
  assign empty = !hold_valid;
  assign full = hold_valid;
  assign head = hold;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_valid <= 1'b0;
      hold <= '0;
    end else begin
      if (accept) hold <= data_in[7:0];
      hold_valid <= accept || (hold_valid && !pop);
    end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      overflow <= 1'b0;
    end else begin
      if (en && |write_enable) overflow <= addr[2] ? 1'b0 : (overflow || (full && !pop));
      baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + BW'(1);
      case (state)
        IDLE:
          if (pop) begin
            shift <= head;
            tx <= 1'b0;
            state <= START;
          end
        START:
          if (bit_end) begin
            tx <= shift[0];
            bit_cnt <= '0;
            state <= DATA;
          end
        DATA:
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              tx <= 1'b1;
              state <= STOP;
            end else begin
              shift <= shift >> 1;
              tx <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        STOP:
          if (bit_end) begin
            if (pop) begin
              shift <= head;
              tx <= 1'b0;
              state <= START;
            end else state <= IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: scoreboard bench; a frame-level model predicts each byte's start edge and data,
// and a tx monitor decodes frames independently and compares them against the queue.
module tb_uart_tx_dev;
  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic clk = 0, rst = 1, en = 0, tx;
  logic [2:0] write_enable = 0;
  logic [31:0] addr = 0, data_in = 0, data_out;
  int cyc = 0, tests = 0, fails = 0;
  logic ovf = 0;
  int starts[$];
  int exp_s[$];
  logic [7:0] exp_b[$];

  uart_tx_dev #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .write_enable(write_enable), .addr(addr),
    .data_in(data_in), .data_out(data_out), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // bytes waiting = accepted bytes whose start edge is still in the future
  function automatic logic [31:0] model_status(input int t);
    int cnt;
    logic bsy;
    cnt = 0;
    bsy = 0;
    foreach (starts[i]) begin
      if (starts[i] > t) cnt++;
      if (starts[i] <= t && t < starts[i] + FRAME) bsy = 1;
    end
    return {28'h0, ovf, cnt == 0, cnt == DEPTH, bsy || cnt != 0};
  endfunction

  task automatic idle();
    @(negedge clk);
    en = 0;
    write_enable = 0;
  endtask

  task automatic idle_until(input int t);
    while (cyc < t) idle();
  endtask

  task automatic wait_quiet();
    logic [31:0] st;
    do begin
      idle();
      st = model_status(cyc);
    end while (st[0]);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w, input logic e);
    int t, c, s;
    @(negedge clk);
    en = e;
    addr = a;
    data_in = d;
    write_enable = w;
    t = cyc + 1;
    if (e && w != 0) begin
      if (a[2]) ovf = 0;
      else begin
        c = 0;
        foreach (starts[i]) if (starts[i] > t) c++;
        if (c < DEPTH) begin
          s = t + 1;
          if (starts.size() > 0 && starts[$] + FRAME > s) s = starts[$] + FRAME;
          starts.push_back(s);
          exp_s.push_back(s);
          exp_b.push_back(d[7:0]);
        end else ovf = 1;
      end
    end
  endtask

  task automatic bus_rd(input logic [31:0] a);
    @(negedge clk);
    en = 1;
    addr = a;
    write_enable = 0;
    #1;
    check(a[2] ? "status_read" : "data_read", data_out, a[2] ? model_status(cyc) : 32'h0);
  endtask

  initial begin
    logic [9:0] f;
    int s;
    bit ab;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        s = cyc;
        ab = 0;
        f = '0;
        for (int k = 1; k < FRAME && !ab; k++) begin
          @(negedge clk);
          if (rst) ab = 1;
          else if (k % CPB == CPB / 2) f = {tx, f[9:1]};
        end
        if (!ab) begin
          if (exp_b.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL frame: unexpected frame at cycle %0d got %h expected none", s, f[8:1]);
          end else begin
            check("frame_start", 32'(s), 32'(exp_s.pop_front()));
            check("frame_data", {24'h0, f[8:1]}, {24'h0, exp_b.pop_front()});
            check("frame_bits", {30'h0, f[9], f[0]}, 32'h2);
          end
        end
      end
    end
  end

  initial begin
    int e0, s0, op, n;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, tx}, 32'h1);
    en = 1;
    addr = 32'h4;
    #1 check("rst_status", data_out, 32'h4);
    en = 0;
    #1 tests++;
    if (data_out === 32'h4) begin
      fails++;
      $display("FAIL released: got %h expected bus released", data_out);
    end
    rst = 0;
    bus_wr(32'h2000_0000, 32'hDEAD_BEA5, 3'b100, 1);
    e0 = cyc + 1;
    idle_until(e0 + FRAME - 1);
    bus_rd(32'h2000_0004);
    check("busy_last", {31'h0, data_out[0]}, 32'h1);
    bus_rd(32'h2000_0004);
    check("busy_drop", {31'h0, data_out[0]}, 32'h0);
    bus_rd(32'h2000_0000);
    wait_quiet();
    bus_wr(32'h0, 32'h01, 3'b001, 1);
    bus_wr(32'h0, 32'h02, 3'b010, 1);
    wait_quiet();
    for (int i = 0; i < 6; i++) begin
      bus_wr(32'h2000_0000, 32'h10 + i, 3'b100, 1);
      if (i == 0) s0 = starts[$];
    end
    bus_rd(32'h2000_0004);
    check("status_ovf", data_out, 32'hB);
    bus_wr(32'h2000_0004, 32'hFFFF_FFFF, 3'b001, 1);
    bus_rd(32'h2000_0004);
    check("status_clr", data_out, 32'h3);
    idle_until(s0 + FRAME - 2);
    bus_wr(32'h2000_0000, 32'h3C, 3'b100, 1);
    bus_rd(32'h2000_0004);
    check("pushpop_full", {31'h0, data_out[3]}, 32'h0);
    wait_quiet();
    bus_wr(32'h0, 32'h5A, 3'b100, 1);
    repeat (13) idle();
    @(negedge clk);
    rst = 1;
    #1 check("midrst_tx", {31'h0, tx}, 32'h1);
    starts.delete();
    exp_s.delete();
    exp_b.delete();
    ovf = 0;
    en = 1;
    addr = 32'h4;
    #1 check("midrst_status", data_out, 32'h4);
    en = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      a = $urandom;
      a[2] = 0;
      if (op <= 4) begin
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) bus_wr(a, $urandom, 3'($urandom_range(1, 7)), 1);
      end else if (op == 5) begin
        a[2] = 1;
        bus_rd(a);
      end else if (op == 6) bus_rd(a);
      else if (op == 7) begin
        a[2] = 1;
        bus_wr(a, $urandom, 3'($urandom_range(1, 7)), 1);
      end else if (op == 8) bus_wr(a, $urandom, 3'($urandom_range(1, 7)), 0);
      else repeat (30) idle();
      repeat ($urandom_range(0, 25)) idle();
    end
    wait_quiet();
    repeat (5) idle();
    check("drain", 32'(exp_b.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
